// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared PRBS LFSR types and default polynomial
package lfsr_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  localparam int         LFSR_N    = 8;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'hFF;

endpackage

// File: rtl/lfsr_step.sv
// rtl/lfsr_step.sv - Fibonacci LFSR feedback bit, shared by generator and checker
module lfsr_step #(
  parameter int           N    = lfsr_pkg::LFSR_N,
  parameter logic [N-1:0] TAPS = lfsr_pkg::LFSR_TAPS
) (
  input  logic [N-1:0] sr,
  output logic         nxt
);

  assign nxt = ^(sr & TAPS);

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - serial PRBS checker: hunt, lock, error flag/count
// err_cnt/clr_err are built only when LFSR_CHK_ERR_CNT_EN is defined.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int           N        = LFSR_N,
  parameter logic [N-1:0] TAPS     = LFSR_TAPS,
  parameter int           LOCK_CNT = 16,
  parameter int           LOSS_CNT = 8,
  parameter int           ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int FILL_W  = $clog2(N + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(LOSS_CNT + 1);

  chk_state_t         state;
  logic [N-1:0]       sr;
  logic [FILL_W-1:0]  fill_cnt;
  logic [MATCH_W-1:0] match_cnt;
  logic [MISS_W-1:0]  miss_cnt;
  logic               p;
  logic               x;
  logic               bit_miss;
  logic               err_hit;

  lfsr_step #(.N(N), .TAPS(TAPS)) u_step (
    .sr  (sr),
    .nxt (p)
  );

  // In LOCKED the register free-runs on its own prediction so line errors do not propagate.
  assign x        = (state == HUNT) ? din : p;
  assign bit_miss = (din != p);
  assign err_hit  = en && (state == LOCKED) && bit_miss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      sr        <= '1;
      fill_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (en) begin
        sr <= {sr[N-2:0], x};
        if (state == HUNT) begin
          if (fill_cnt < FILL_W'(N)) begin
            fill_cnt <= fill_cnt + 1'b1;
          end else if (bit_miss || (sr == '0)) begin
            // An all-zero register trivially predicts a zero line; never let it lock.
            match_cnt <= '0;
          end else if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
            match_cnt <= match_cnt + 1'b1;
            state     <= LOCKED;
            locked    <= 1'b1;
            miss_cnt  <= '0;
          end else begin
            match_cnt <= match_cnt + 1'b1;
          end
        end else begin
          if (bit_miss) begin
            err_pulse <= 1'b1;
            miss_cnt  <= miss_cnt + 1'b1;
            if (miss_cnt == MISS_W'(LOSS_CNT - 1)) begin
              state     <= HUNT;
              locked    <= 1'b0;
              fill_cnt  <= '0;
              match_cnt <= '0;
            end
          end else if (miss_cnt != '0) begin
            miss_cnt <= miss_cnt - 1'b1;
          end
        end
      end
    end
  end

`ifdef LFSR_CHK_ERR_CNT_EN
  logic [ERR_W-1:0] err_cnt_q;

  // clr_err wins over a coincident error, which is therefore dropped from the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (clr_err) begin
      err_cnt_q <= '0;
    end else if (err_hit && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err_inputs;

  assign unused_err_inputs = clr_err ^ err_hit;
  assign err_cnt           = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - directed self-checking bench for lfsr_checker
module tb_lfsr_checker;
  import lfsr_pkg::*;

`ifdef LFSR_CHK_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, din, clr_err;
  logic        locked, err_pulse;
  logic [15:0] err_cnt;
  logic        locked4, err_pulse4;
  logic [3:0]  err_cnt4;

  lfsr_checker dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr_err(clr_err),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  lfsr_checker #(.ERR_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr_err(clr_err),
    .locked(locked4), .err_pulse(err_pulse4), .err_cnt(err_cnt4)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         pulses   = 0;
  int         pulses4  = 0;
  logic [7:0] gen_sr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic logic [31:0] cnt_exp(input int v);
    return CNT_EN ? 32'(v) : 32'd0;
  endfunction

  task automatic tick(input logic e, input logic d, input logic c);
    en = e; din = d; clr_err = c;
    @(posedge clk); #1;
    if (err_pulse)  pulses++;
    if (err_pulse4) pulses4++;
  endtask

  task automatic send(input logic inv, input logic c);
    logic b;
    b      = ^(gen_sr & 8'hB8);
    gen_sr = {gen_sr[6:0], b};
    tick(1'b1, b ^ inv, c);
  endtask

  task automatic do_reset;
    rst = 1'b1; en = 1'b0; din = 1'b0; clr_err = 1'b0;
    #2;
    check("rst_async_locked", {31'd0, locked}, 32'd0);
    @(posedge clk); #1;
    rst     = 1'b0;
    gen_sr  = LFSR_SEED;
    pulses  = 0;
    pulses4 = 0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_lock, bad_pulse, bad_cnt, seen_lock, gaps;
    rst = 1'b0; en = 1'b0; din = 1'b0; clr_err = 1'b0; gen_sr = LFSR_SEED;
    #1;

    // Scenario 1: idle after reset
    do_reset();
    bad_lock = 0; bad_pulse = 0; bad_cnt = 0;
    repeat (10) begin
      tick(1'b0, 1'b0, 1'b0);
      if (locked !== 1'b0)    bad_lock++;
      if (err_pulse !== 1'b0) bad_pulse++;
      if (err_cnt !== 16'd0)  bad_cnt++;
    end
    check("idle_locked_cycles", bad_lock, 0);
    check("idle_pulse_cycles", bad_pulse, 0);
    check("idle_errcnt_cycles", bad_cnt, 0);

    // Scenario 2: clean stream with random en gaps
    do_reset();
    bad_lock = 0;
    for (int k = 1; k <= 1000; k++) begin
      gaps = $urandom_range(0, 2);
      repeat (gaps) begin
        tick(1'b0, 1'b0, 1'b0);
        if (locked !== ((k - 1) >= 24)) bad_lock++;
      end
      send(1'b0, 1'b0);
      if (k == 23) check("lock_after_bit23", {31'd0, locked}, 32'd0);
      if (k == 24) check("lock_after_bit24", {31'd0, locked}, 32'd1);
      if (locked !== (k >= 24)) bad_lock++;
    end
    check("clean_lock_track", bad_lock, 0);
    check("clean_pulses", pulses, 0);
    check("clean_err_cnt", {16'd0, err_cnt}, 32'd0);

    // Scenario 3: single inverted bit 100
    do_reset();
    for (int k = 1; k <= 200; k++) begin
      send(k == 100, 1'b0);
      if (k == 100) check("pulse_on_bit100", {31'd0, err_pulse}, 32'd1);
      tick(1'b0, 1'b0, 1'b0);
      if (k == 100) check("pulse_after_gap", {31'd0, err_pulse}, 32'd0);
    end
    check("single_err_pulses", pulses, 1);
    check("single_err_cnt", {16'd0, err_cnt}, cnt_exp(1));
    check("single_err_locked", {31'd0, locked}, 32'd1);

    // Scenario 4: switch to inverted stream after lock
    do_reset();
    repeat (50) send(1'b0, 1'b0);
    check("inv_pre_locked", {31'd0, locked}, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      send(1'b1, 1'b0);
      if (i == 7) check("inv_locked_after7", {31'd0, locked}, 32'd1);
      if (i == 8) begin
        check("inv_locked_after8", {31'd0, locked}, 32'd0);
        check("inv_pulse_on8", {31'd0, err_pulse}, 32'd1);
      end
    end
    check("inv_pulses", pulses, 8);
    check("inv_err_cnt", {16'd0, err_cnt}, cnt_exp(8));
    pulses = 0; seen_lock = 0;
    repeat (300) begin
      send(1'b1, 1'b0);
      if (locked) seen_lock++;
    end
    check("inv_hunt_locked", seen_lock, 0);
    check("inv_hunt_pulses", pulses, 0);
    check("inv_hunt_err_cnt", {16'd0, err_cnt}, cnt_exp(8));

    // Scenario 5: constant-zero line must never lock
    do_reset();
    seen_lock = 0;
    repeat (200) begin
      tick(1'b1, 1'b0, 1'b0);
      if (locked) seen_lock++;
    end
    check("zero_line_locked", seen_lock, 0);
    check("zero_line_pulses", pulses, 0);

    // Scenario 6: saturation and clear on the 4-bit counter
    do_reset();
    repeat (50) send(1'b0, 1'b0);
    repeat (20) begin
      send(1'b1, 1'b0);
      repeat (3) send(1'b0, 1'b0);
    end
    check("sat_locked4", {31'd0, locked4}, 32'd1);
    check("sat_pulses4", pulses4, 20);
    check("sat_err_cnt4", {28'd0, err_cnt4}, cnt_exp(15));
    check("sat_err_cnt16", {16'd0, err_cnt}, cnt_exp(20));
    send(1'b1, 1'b1);
    check("clr_err_cnt4", {28'd0, err_cnt4}, 32'd0);
    check("clr_pulse4", {31'd0, err_pulse4}, 32'd1);
    check("clr_err_cnt16", {16'd0, err_cnt}, 32'd0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    check("post_clr_err_cnt4", {28'd0, err_cnt4}, cnt_exp(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Serial PRBS checker: the receive end of the team's Fibonacci LFSR generator. Synchronises to the incoming pseudo-random bit stream, declares lock, then flags every bit that departs from the locally predicted sequence. Sits after the link or loopback under test and feeds link-quality status (lock, error pulses, error count) to the control logic.

## Interface

- N, 8, LFSR width; must equal the generator's width.
- TAPS, 8'hB8, N-bit feedback mask; must equal the generator's mask.
- LOCK_CNT, 16, consecutive matching bits required after fill to declare lock.
- LOSS_CNT, 8, leaky-bucket threshold for loss of lock.
- ERR_W, 16, error counter width.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  din is valid this cycle; all state is held when low.
- din  in  1  received serial bit.
- clr_err  in  1  synchronous clear of err_cnt.
- locked  out  1  checker is in LOCKED.
- err_pulse  out  1  one-cycle flag: mismatch detected while locked.
- err_cnt  out  ERR_W  saturating mismatch count.

## Operation

- Shift register sr[N-1:0].
  - Predicted bit p = ^(sr & TAPS).
  - Advance: sr <= {sr[N-2:0], x}.
  - This is identical to the generator, which transmits its new bit each step.
- State HUNT (reset state):
  - On each en, x = din, so sr is reloaded from the line.
  - A fill counter counts up to N. While the fill counter is below N, no comparison is made.
  - Once filled:
    - din == p increments the match counter.
    - A mismatch clears the match counter.
    - sr == 0 also clears the match counter. All-zero is an invalid LFSR state and must never produce lock.
  - When the match counter reaches LOCK_CNT, go to LOCKED. Clear the miss counter.
- State LOCKED:
  - On each en, x = p. The checker free-runs, so line errors are not fed back and do not multiply.
  - On mismatch:
    - err_pulse = 1.
    - err_cnt increments, saturating at all-ones.
    - The miss counter increments.
  - On match, the miss counter decrements, with a floor of 0.
  - When the miss counter reaches LOSS_CNT, go to HUNT. Clear the fill and match counters. sr is kept and is reloaded from the line on subsequent bits.
- clr_err:
  - Sets err_cnt to 0.
  - Has priority over a coincident increment; that error is not counted.
  - err_pulse still fires for the coincident error.
- Reset values: state = HUNT, sr = all-ones, all counters = 0, locked = 0, err_pulse = 0, err_cnt = 0.

## Timing

- All outputs are registered. Each reflects the en bit sampled on the previous rising edge.
- locked rises in the cycle after the edge that samples bit N+LOCK_CNT of a clean stream. With defaults this is bit 24.
- locked falls in the cycle after the edge that samples the mismatch bringing the miss counter to LOSS_CNT.
  - That mismatch still produces err_pulse and is counted.
- err_pulse is high for exactly one cycle per erroneous en bit.
  - It is low in every cycle that follows an en = 0 cycle.
  - It is never asserted in HUNT.
- Gaps in en (any length) do not affect lock or counters.
- Asserting rst at any time returns every register to its reset value immediately. Operation resumes on the first edge after rst is released.

## Configuration

- `LFSR_CHK_ERR_CNT_EN` defined:
  - err_cnt is implemented as specified.
  - clr_err is functional.
- `LFSR_CHK_ERR_CNT_EN` undefined:
  - err_cnt is tied to 0 and clr_err is ignored.
  - No counter flops are synthesised.
  - err_pulse, locked and the miss counter are unchanged.

## Structure

- Package lfsr_pkg holds:
  - typedef chk_state_t {HUNT, LOCKED}.
  - Default width and taps constants, shared with the generator.
- Sub-module lfsr_step: combinational, takes sr and TAPS and returns the next bit. It is shared with the generator so both ends use one polynomial definition.
- All remaining state (sr, counters, FSM) lives in lfsr_checker.

## Test plan

All scenarios use the defaults. The generator is seeded with 8'hFF.

1. Reset with en = 0 for 10 cycles.
   - Response: locked = 0, err_pulse = 0, err_cnt = 0 throughout.
2. Clean PRBS stream with random en gaps.
   - Response: locked rises exactly one cycle after valid bit 24. err_cnt stays 0 over 1000 bits.
3. After lock, invert valid bit 100 only.
   - Response: exactly one err_pulse. err_cnt = 1. locked stays 1.
4. After lock, switch to the inverted stream.
   - Response: locked drops after 8 consecutive errors, and err_cnt = 8.
   - Checker stays in HUNT indefinitely: with four taps, an inverted stream always mismatches.
5. Constant-zero din for 200 bits from reset.
   - Response: locked never rises.
6. Saturation and clear, with ERR_W = 4 after lock.
   - 20 isolated errors: err_cnt = 15.
   - clr_err coincident with the next error: err_cnt = 0 and err_pulse = 1.
   - Rebuild with `LFSR_CHK_ERR_CNT_EN` undefined: err_cnt stays 0.
